// File: rtl/xnor2_gate.sv
// Bitwise 2-input XNOR with an optional registered stage carrying a valid flag,
// an all-bits-equal flag and a count of equal bit positions.
module xnor2_gate #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] F,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic [WIDTH-1:0] F_q,
    output logic             out_valid,
    output logic             eq_all_q,
    output logic [CNT_W-1:0] eq_count_q
);

    logic             eq_all_d;
    logic [CNT_W-1:0] eq_count_d;

    // Pure gate path: no clock, reset or valid involvement.
    assign F = ~(A ^ B);

    always_comb begin
        eq_all_d   = (A == B);
        eq_count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            eq_count_d = eq_count_d + CNT_W'(F[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_q        <= '0;
            out_valid  <= 1'b0;
            eq_all_q   <= 1'b0;
            eq_count_q <= '0;
        end else begin
            // out_valid marks a fresh capture; payload holds between captures.
            out_valid <= in_valid;
            if (in_valid) begin
                F_q        <= F;
                eq_all_q   <= eq_all_d;
                eq_count_q <= eq_count_d;
            end
        end
    end

endmodule

// File: tb/tb_xnor2_gate.sv
// Directed self-checking bench for xnor2_gate: WIDTH=1 truth table and a
// WIDTH=8 instance exercising capture, hold, back-to-back and async reset.
module tb_xnor2_gate;

    logic       clk;
    logic       rst_n;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] f8;
    logic       in_valid;
    logic [7:0] f8_q;
    logic       out_valid;
    logic       eq_all_q;
    logic [3:0] eq_count_q;

    logic       a1;
    logic       b1;
    logic       f1;
    logic       f1_q;
    logic       ov1;
    logic       eqa1;
    logic       eqc1;

    int n_checks = 0;
    int n_errors = 0;

    xnor2_gate #(.WIDTH(8)) u_dut8 (
        .A          (a8),
        .B          (b8),
        .F          (f8),
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .F_q        (f8_q),
        .out_valid  (out_valid),
        .eq_all_q   (eq_all_q),
        .eq_count_q (eq_count_q)
    );

    xnor2_gate #(.WIDTH(1)) u_dut1 (
        .A          (a1),
        .B          (b1),
        .F          (f1),
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (1'b0),
        .F_q        (f1_q),
        .out_valid  (ov1),
        .eq_all_q   (eqa1),
        .eq_count_q (eqc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // {A, B, expected F, expected equal-bit count}
    logic [7:0] vec_a [3] = '{8'h12, 8'hAA, 8'h81};
    logic [7:0] vec_b [3] = '{8'h34, 8'h55, 8'h80};
    logic [7:0] vec_f [3] = '{8'hD9, 8'h00, 8'hFE};
    logic [3:0] vec_c [3] = '{4'd5, 4'd0, 4'd7};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a8       = 8'h00;
        b8       = 8'h00;
        a1       = 1'b0;
        b1       = 1'b0;

        // WIDTH=1 truth table, no clock dependence.
        #1 check_val("w1_00", 32'(f1), 32'd1);
        b1 = 1'b1;
        #1 check_val("w1_01", 32'(f1), 32'd0);
        a1 = 1'b1; b1 = 1'b0;
        #1 check_val("w1_10", 32'(f1), 32'd0);
        b1 = 1'b1;
        #1 check_val("w1_11", 32'(f1), 32'd1);

        // Reset state.
        next_edge();
        check_val("rst_fq", 32'(f8_q), 32'h00);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_eqall", 32'(eq_all_q), 32'd0);
        check_val("rst_eqcnt", 32'(eq_count_q), 32'd0);
        rst_n = 1'b1;
        next_edge();

        // Single capture of F0 xnor CC.
        a8 = 8'hF0; b8 = 8'hCC; in_valid = 1'b1;
        #1 check_val("comb_c3", 32'(f8), 32'hC3);
        next_edge();
        check_val("cap_fq", 32'(f8_q), 32'hC3);
        check_val("cap_cnt", 32'(eq_count_q), 32'd4);
        check_val("cap_eqall", 32'(eq_all_q), 32'd0);
        check_val("cap_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        next_edge();
        check_val("pulse_valid", 32'(out_valid), 32'd0);
        check_val("pulse_hold", 32'(f8_q), 32'hC3);

        // Equal operands.
        a8 = 8'h5A; b8 = 8'h5A; in_valid = 1'b1;
        #1 check_val("comb_ff", 32'(f8), 32'hFF);
        next_edge();
        check_val("eq_fq", 32'(f8_q), 32'hFF);
        check_val("eq_eqall", 32'(eq_all_q), 32'd1);
        check_val("eq_cnt", 32'(eq_count_q), 32'd8);

        // Fully complementary operands.
        a8 = 8'h00; b8 = 8'hFF;
        #1 check_val("comb_00", 32'(f8), 32'h00);
        next_edge();
        check_val("cmp_cnt", 32'(eq_count_q), 32'd0);
        check_val("cmp_eqall", 32'(eq_all_q), 32'd0);

        // Back-to-back captures, operands changing each cycle.
        for (int i = 0; i < 3; i++) begin
            a8 = vec_a[i]; b8 = vec_b[i]; in_valid = 1'b1;
            next_edge();
            check_val($sformatf("b2b_fq_%0d", i), 32'(f8_q), 32'(vec_f[i]));
            check_val($sformatf("b2b_cnt_%0d", i), 32'(eq_count_q), 32'(vec_c[i]));
            check_val($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        a8 = 8'h3C; b8 = 8'h0F;
        next_edge();
        check_val("drop_valid", 32'(out_valid), 32'd0);
        check_val("drop_fq", 32'(f8_q), 32'hFE);
        check_val("drop_cnt", 32'(eq_count_q), 32'd7);

        // Async reset between edges after a capture.
        a8 = 8'hA5; b8 = 8'hA5; in_valid = 1'b1;
        next_edge();
        check_val("pre_rst_eqall", 32'(eq_all_q), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_val("arst_fq", 32'(f8_q), 32'h00);
        check_val("arst_valid", 32'(out_valid), 32'd0);
        check_val("arst_eqall", 32'(eq_all_q), 32'd0);
        check_val("arst_cnt", 32'(eq_count_q), 32'd0);
        a8 = 8'h0F; b8 = 8'h33;
        #1 check_val("arst_comb", 32'(f8), 32'hC3);
        next_edge();
        check_val("rst_held_valid", 32'(out_valid), 32'd0);
        check_val("rst_held_fq", 32'(f8_q), 32'h00);
        rst_n = 1'b1;
        next_edge();
        check_val("post_rst_fq", 32'(f8_q), 32'hC3);
        check_val("post_rst_valid", 32'(out_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
